// File: rtl/mips_encode_pkg.sv
// Shared encodings for the MIPS instruction encoder: KIND_* selectors, OP_*/OP0_* field values
// and the combinational pack function used by mips_encode.
package mips_encode_pkg;

    typedef enum logic [4:0] {
        KIND_ADD  = 5'd0,  KIND_SUB  = 5'd1,  KIND_AND  = 5'd2,  KIND_OR   = 5'd3,
        KIND_NOR  = 5'd4,  KIND_XOR  = 5'd5,  KIND_SLT  = 5'd6,  KIND_JR   = 5'd7,
        KIND_ADDM = 5'd8,  KIND_ADDI = 5'd9,  KIND_ANDI = 5'd10, KIND_ORI  = 5'd11,
        KIND_XORI = 5'd12, KIND_LUI  = 5'd13, KIND_LW   = 5'd14, KIND_LBU  = 5'd15,
        KIND_SW   = 5'd16, KIND_SB   = 5'd17, KIND_BEQ  = 5'd18, KIND_BNE  = 5'd19,
        KIND_J    = 5'd20
    } kind_e;

    localparam logic [5:0] OP_OTHER0 = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] OP0_JR    = 6'h08;
    localparam logic [5:0] OP0_ADD   = 6'h20;
    localparam logic [5:0] OP0_SUB   = 6'h22;
    localparam logic [5:0] OP0_AND   = 6'h24;
    localparam logic [5:0] OP0_OR    = 6'h25;
    localparam logic [5:0] OP0_XOR   = 6'h26;
    localparam logic [5:0] OP0_NOR   = 6'h27;
    localparam logic [5:0] OP0_SLT   = 6'h2a;
    localparam logic [5:0] OP0_ADDM  = 6'h2c;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OP_OTHER0, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Instructions that are followed by a delay-slot NOP when padding is enabled.
    function automatic logic is_delay_branch(input logic [4:0] kind);
        return (kind == KIND_BEQ) || (kind == KIND_BNE) || (kind == KIND_J) || (kind == KIND_JR);
    endfunction

    function automatic enc_t encode(input logic [4:0] kind, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [15:0] imm, input logic [25:0] target);
        enc_t e;
        e.legal = 1'b1;
        e.word  = 32'h0000_0000;
        case (kind)
            KIND_ADD:  e.word = r_type(rs, rt, rd, OP0_ADD);
            KIND_SUB:  e.word = r_type(rs, rt, rd, OP0_SUB);
            KIND_AND:  e.word = r_type(rs, rt, rd, OP0_AND);
            KIND_OR:   e.word = r_type(rs, rt, rd, OP0_OR);
            KIND_NOR:  e.word = r_type(rs, rt, rd, OP0_NOR);
            KIND_XOR:  e.word = r_type(rs, rt, rd, OP0_XOR);
            KIND_SLT:  e.word = r_type(rs, rt, rd, OP0_SLT);
            KIND_ADDM: e.word = r_type(rs, rt, rd, OP0_ADDM);
            KIND_JR:   e.word = {OP_OTHER0, rs, 15'h0000, OP0_JR};
            KIND_ADDI: e.word = i_type(OP_ADDI, rs, rt, imm);
            KIND_ANDI: e.word = i_type(OP_ANDI, rs, rt, imm);
            KIND_ORI:  e.word = i_type(OP_ORI,  rs, rt, imm);
            KIND_XORI: e.word = i_type(OP_XORI, rs, rt, imm);
            KIND_LW:   e.word = i_type(OP_LW,   rs, rt, imm);
            KIND_LBU:  e.word = i_type(OP_LBU,  rs, rt, imm);
            KIND_SW:   e.word = i_type(OP_SW,   rs, rt, imm);
            KIND_SB:   e.word = i_type(OP_SB,   rs, rt, imm);
            KIND_BEQ:  e.word = i_type(OP_BEQ,  rs, rt, imm);
            KIND_BNE:  e.word = i_type(OP_BNE,  rs, rt, imm);
            KIND_LUI:  e.word = i_type(OP_LUI,  5'd0, rt, imm);
            KIND_J:    e.word = {OP_J, target};
            default: begin
                e.legal = 1'b0;
                e.word  = 32'h0000_0000;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mips_enc_fifo.sv
// Small synchronous FIFO holding {word, address} pairs for mips_encode.
// Push is refused when full (even with a concurrent pop); flush empties it in one cycle.
module mips_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    import mips_encode_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_push_s;
    logic         do_pop_s;

    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign rdata = mem_q[rd_ptr_q[PW-1:0]];

    // Next-state for pointers and storage; flush wins over push/pop.
    always_comb begin
        do_push_s = push & ~full & ~flush;
        do_pop_s  = pop & ~empty & ~flush;
        mem_d     = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q[PW-1:0]] = wdata;
        end else begin
            mem_d = mem_q;
        end
        if (flush) begin
            wr_ptr_d = rd_ptr_q;
            rd_ptr_d = rd_ptr_q;
        end else begin
            wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        end
    end

    // State registers; storage is cleared on reset so the head reads as zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/mips_encode.sv
// MIPS instruction encoder: packs symbolic instructions into 32-bit words with byte addresses.
// Optional build macro MIPS_ENC_DELAY_SLOT_EN appends a NOP after every BEQ/BNE/J/JR.
module mips_encode #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_count
);
    import mips_encode_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] ADDR_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              ready_en_q, ready_en_d;
    logic              pad_pending_q, pad_pending_d;

    enc_t                enc_s;
    logic                accept_s;
    logic                pad_push_s;
    logic                push_s;
    logic [31:0]         push_word_s;
    logic                full_s;
    logic                empty_s;
    logic [ADDR_W+31:0]  fifo_rdata_s;

    assign enc_s = encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);

    // Handshake, push selection and next-state for counter, error status and padding.
    always_comb begin
        in_ready    = ready_en_q & ~full_s & ~start & ~pad_pending_q;
        accept_s    = in_valid & in_ready;
        pad_push_s  = pad_pending_q & ~full_s & ~start;
        push_s      = pad_push_s | (accept_s & enc_s.legal);
        push_word_s = pad_push_s ? 32'h0000_0000 : enc_s.word;
        ready_en_d  = 1'b1;

        if (start) begin
            addr_d = base_addr & ADDR_MASK;
        end else if (push_s) begin
            addr_d = addr_q + ADDR_STEP;
        end else begin
            addr_d = addr_q;
        end

        if (start) begin
            err_d       = 1'b0;
            err_count_d = 8'd0;
        end else if (accept_s && !enc_s.legal) begin
            err_d       = 1'b1;
            err_count_d = (err_count_q == 8'hff) ? err_count_q : (err_count_q + 8'd1);
        end else begin
            err_d       = err_q;
            err_count_d = err_count_q;
        end

`ifdef MIPS_ENC_DELAY_SLOT_EN
        if (start) begin
            pad_pending_d = 1'b0;
        end else if (accept_s && enc_s.legal && is_delay_branch(in_kind)) begin
            pad_pending_d = 1'b1;
        end else if (pad_push_s) begin
            pad_pending_d = 1'b0;
        end else begin
            pad_pending_d = pad_pending_q;
        end
`else
        pad_pending_d = 1'b0;
`endif
    end

    // Control and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q        <= '0;
            err_q         <= 1'b0;
            err_count_q   <= 8'd0;
            ready_en_q    <= 1'b0;
            pad_pending_q <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
            ready_en_q    <= ready_en_d;
            pad_pending_q <= pad_pending_d;
        end
    end

    mips_enc_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + 32)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (start),
        .push  (push_s),
        .pop   (out_ready & ~start),
        .wdata ({push_word_s, addr_q}),
        .rdata (fifo_rdata_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign out_valid = ~empty_s;
    assign out_word  = fifo_rdata_s[ADDR_W+31:ADDR_W];
    assign out_addr  = fifo_rdata_s[ADDR_W-1:0];
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule
